fir_stim_gen: RTL



---
 rtl/fir_stim_gen_pkg.sv | 27 ++
 rtl/fir_stim_lfsr.sv | 26 ++
 rtl/fir_stim_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fir_stim_gen_pkg.sv
// Shared types and LFSR helpers for the FIR stimulus generator.
package fir_stim_pkg;

  typedef enum logic [1:0] {
    MODE_IMPULSE = 2'd0,
    MODE_STEP    = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_PRBS    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int LFSR_TAP0 = 31;
  localparam int LFSR_TAP1 = 21;
  localparam int LFSR_TAP2 = 1;
  localparam int LFSR_TAP3 = 0;

  // Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3]};
  endfunction

endpackage

// File: rtl/fir_stim_lfsr.sv
// 32-bit PRBS source; holds the last emitted value and presents the next one.
module fir_stim_lfsr
  import fir_stim_pkg::*;
#(
  parameter int          OUT_W = 16,
  parameter logic [31:0] SEED  = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [OUT_W-1:0] next_smp
);

  logic [31:0] state;
  logic [31:0] state_nxt;

  assign state_nxt = lfsr_next(state);
  assign next_smp  = state_nxt[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || load) state <= SEED;
    else if (advance) state <= state_nxt;
  end

endmodule

// File: rtl/fir_stim_gen.sv
// Burst stimulus source for a FIR input port: impulse/step/ramp/PRBS burst,
// zero flush tail, one-cycle done pulse.
module fir_stim_gen
  import fir_stim_pkg::*;
#(
  parameter int          OUTPUT_WIDTH = 16,
  parameter int          LEN_WIDTH    = 16,
  parameter int          FLUSH_LEN    = 37,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [OUTPUT_WIDTH-1:0] amplitude,
  input  logic [LEN_WIDTH-1:0]    length,
  input  logic [7:0]              spacing,
  output logic                    valid_out,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    busy,
  output logic                    done
);

  localparam int             FCW        = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN);

  state_e                  state;
  mode_e                   mode_q;
  logic [OUTPUT_WIDTH-1:0] amp_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [7:0]              spc_q;
  logic [LEN_WIDTH-1:0]    samp_cnt;
  logic [FCW-1:0]          flush_cnt;
  logic [7:0]              spc_cnt;
  logic [OUTPUT_WIDTH-1:0] acc;

  logic                    start_ok;
  logic                    slot;
  logic                    more_burst;
  logic                    more_flush;
  logic                    lfsr_adv;
  logic [OUTPUT_WIDTH-1:0] prbs_nxt;
  logic [OUTPUT_WIDTH-1:0] first_smp;
  logic [OUTPUT_WIDTH-1:0] burst_smp;

  assign start_ok   = (state == ST_IDLE) && start && !abort;
  assign slot       = (spc_cnt == 8'd0);
  assign more_burst = (samp_cnt != len_q);
  assign more_flush = (flush_cnt != FLUSH_LAST);
  assign lfsr_adv   = (state == ST_RUN) && slot && more_burst && (mode_q == MODE_PRBS) && !abort;

  fir_stim_lfsr #(
    .OUT_W (OUTPUT_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .advance  (lfsr_adv),
    .next_smp (prbs_nxt)
  );

  // Sample 0 comes straight from the start inputs so it is out the cycle after start.
  always_comb begin
    first_smp = '0;
    case (mode_e'(mode))
      MODE_IMPULSE: first_smp = amplitude;
      MODE_STEP:    first_smp = amplitude;
      MODE_RAMP:    first_smp = '0;
      MODE_PRBS:    first_smp = LFSR_SEED[OUTPUT_WIDTH-1:0];
    endcase
  end

  // Samples k >= 1 from the captured config.
  always_comb begin
    burst_smp = '0;
    case (mode_q)
      MODE_IMPULSE: burst_smp = '0;
      MODE_STEP:    burst_smp = amp_q;
      MODE_RAMP:    burst_smp = acc + amp_q;
      MODE_PRBS:    burst_smp = prbs_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= ST_IDLE;
      valid_out <= 1'b0;
      dout      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode_q    <= MODE_IMPULSE;
      amp_q     <= '0;
      len_q     <= '0;
      spc_q     <= '0;
      samp_cnt  <= '0;
      flush_cnt <= '0;
      spc_cnt   <= '0;
      acc       <= '0;
    end else begin
      done      <= 1'b0;
      valid_out <= 1'b0;
      dout      <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode_e'(mode);
            amp_q     <= amplitude;
            len_q     <= length;
            spc_q     <= spacing;
            spc_cnt   <= spacing;
            acc       <= '0;
            flush_cnt <= '0;
            samp_cnt  <= '0;
            if (length != '0) begin
              state     <= ST_RUN;
              valid_out <= 1'b1;
              dout      <= first_smp;
              busy      <= 1'b1;
              samp_cnt  <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end else if (FLUSH_LEN > 0) begin
              state     <= ST_FLUSH;
              valid_out <= 1'b1;
              busy      <= 1'b1;
              flush_cnt <= {{(FCW-1){1'b0}}, 1'b1};
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN, ST_FLUSH: begin
          if (!slot) begin
            spc_cnt <= spc_cnt - 8'd1;
          end else begin
            // The spacing window spans the RUN->FLUSH boundary unchanged.
            spc_cnt <= spc_q;
            if ((state == ST_RUN) && more_burst) begin
              valid_out <= 1'b1;
              dout      <= burst_smp;
              acc       <= burst_smp;
              samp_cnt  <= samp_cnt + 1'b1;
            end else if (more_flush) begin
              state     <= ST_FLUSH;
              valid_out <= 1'b1;
              flush_cnt <= flush_cnt + 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
